// File: rtl/ami_dma_sched.sv
// ami_dma_sched: round-robin arbiter that feeds single DMA commands from
// NREQ requesters into one DMA engine. It then waits for the engine's
// completion irq, clears it, and reports done/error to the owner.
// Optional BUSY watchdog: define AMI_DMA_SCHED_WDOG_EN.
module ami_dma_sched #(
    parameter int NREQ    = 4,
    parameter int IW      = $clog2(NREQ),
    parameter int TIMEOUT = 65535
) (
    input  logic                usr_clk,
    input  logic                usr_reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*32-1:0]  req_sa,
    input  logic [NREQ*32-1:0]  req_len,
    output logic [NREQ-1:0]     req_done,
    output logic [3:0]          req_err,
    output logic                cfg_dma_valid,
    input  logic                cfg_dma_ready,
    output logic [31:0]         cfg_dma_sa,
    output logic [31:0]         cfg_dma_len,
    input  logic                dma_irq,
    output logic                dma_irq_w1c,
    input  logic [3:0]          dma_err,
    output logic                busy,
    output logic [IW-1:0]       cur_id
);

    typedef enum logic [2:0] {IDLE, CFG, BUSY, CLR, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   cur_id_q, cur_id_d;
    logic [31:0]     sa_q, sa_d;
    logic [31:0]     len_q, len_d;
    logic [3:0]      err_q, err_d;

`ifdef AMI_DMA_SCHED_WDOG_EN
    // Last count value before the limit; reaching it without irq times out.
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
    logic [15:0]     wd_q, wd_d;
`endif

    logic            gnt_vld;
    logic [IW-1:0]   gnt_idx;
    logic [31:0]     sa_sel, len_sel;
    int              rr_idx;
    logic            rdy_en, cfg_en, w1c_en, done_en;

    // Round-robin pick: first valid requester searching upward from ptr+1.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_idx  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = (int'(ptr_q) + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!gnt_vld && (i == rr_idx) && req_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = IW'(i);
                end
            end
        end
    end

    // Select the granted requester's address/length slice.
    always_comb begin
        sa_sel  = '0;
        len_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(gnt_idx) == i) begin
                sa_sel  = req_sa[i*32 +: 32];
                len_sel = req_len[i*32 +: 32];
            end
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_id_d = cur_id_q;
        sa_d     = sa_q;
        len_d    = len_q;
        err_d    = err_q;
`ifdef AMI_DMA_SCHED_WDOG_EN
        wd_d     = wd_q;
`endif
        rdy_en   = 1'b0;
        cfg_en   = 1'b0;
        w1c_en   = 1'b0;
        done_en  = 1'b0;
        case (state_q)
            IDLE: begin
                // A still-high irq means the engine is not clear yet: hold off.
                rdy_en = gnt_vld && !dma_irq;
                if (rdy_en) begin
                    state_d  = CFG;
                    ptr_d    = gnt_idx;
                    cur_id_d = gnt_idx;
                    sa_d     = sa_sel;
                    len_d    = len_sel;
                end
            end
            CFG: begin
                cfg_en = 1'b1;
                if (cfg_dma_ready) begin
                    state_d = BUSY;
`ifdef AMI_DMA_SCHED_WDOG_EN
                    wd_d    = '0;
`endif
                end
            end
            BUSY: begin
                // A real completion wins over a coincident timeout.
                if (dma_irq) begin
                    err_d   = dma_err;
                    state_d = CLR;
                end
`ifdef AMI_DMA_SCHED_WDOG_EN
                else if (wd_q == WD_LAST) begin
                    err_d   = 4'hF;
                    state_d = CLR;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
`endif
            end
            CLR: begin
                w1c_en  = 1'b1;
                done_en = 1'b1;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!dma_irq) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and command registers with synchronous reset.
    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            state_q  <= IDLE;
            ptr_q    <= IW'(NREQ - 1);
            cur_id_q <= '0;
            sa_q     <= '0;
            len_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cur_id_q <= cur_id_d;
            sa_q     <= sa_d;
            len_q    <= len_d;
            err_q    <= err_d;
        end
    end

`ifdef AMI_DMA_SCHED_WDOG_EN
    // BUSY watchdog counter.
    always_ff @(posedge usr_clk) begin
        if (usr_reset) wd_q <= '0;
        else           wd_q <= wd_d;
    end
`endif

    // Outputs; forced low during reset so an abandoned command never signals.
    always_comb begin
        req_ready     = '0;
        req_done      = '0;
        req_err       = '0;
        cfg_dma_valid = 1'b0;
        cfg_dma_sa    = '0;
        cfg_dma_len   = '0;
        dma_irq_w1c   = 1'b0;
        busy          = 1'b0;
        cur_id        = '0;
        if (!usr_reset) begin
            for (int i = 0; i < NREQ; i++) begin
                req_ready[i] = rdy_en  && (int'(gnt_idx)  == i);
                req_done[i]  = done_en && (int'(cur_id_q) == i);
            end
            req_err       = done_en ? err_q : 4'h0;
            cfg_dma_valid = cfg_en;
            cfg_dma_sa    = sa_q;
            cfg_dma_len   = len_q;
            dma_irq_w1c   = w1c_en;
            busy          = (state_q != IDLE);
            cur_id        = cur_id_q;
        end
    end

endmodule

// File: tb/tb_ami_dma_sched.sv
// Directed, table-driven bench for ami_dma_sched (NREQ=4, TIMEOUT=20).
module tb_ami_dma_sched;

    logic         clk = 1'b0;
    logic         usr_reset;
    logic [3:0]   req_valid, req_ready, req_done;
    logic [127:0] req_sa, req_len;
    logic [3:0]   req_err, dma_err;
    logic         cfg_dma_valid, cfg_dma_ready, dma_irq, dma_irq_w1c, busy;
    logic [31:0]  cfg_dma_sa, cfg_dma_len;
    logic [1:0]   cur_id;

    ami_dma_sched #(.NREQ(4), .TIMEOUT(20)) dut (
        .usr_clk(clk), .usr_reset(usr_reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sa(req_sa), .req_len(req_len),
        .req_done(req_done), .req_err(req_err),
        .cfg_dma_valid(cfg_dma_valid), .cfg_dma_ready(cfg_dma_ready),
        .cfg_dma_sa(cfg_dma_sa), .cfg_dma_len(cfg_dma_len),
        .dma_irq(dma_irq), .dma_irq_w1c(dma_irq_w1c), .dma_err(dma_err),
        .busy(busy), .cur_id(cur_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] rv;
        logic       cr;
        logic       irq;
        logic [3:0] err;
        logic [3:0] e_rdy;
        logic       e_cfgv;
        logic       e_busy;
        logic [3:0] e_done;
        logic       e_w1c;
        logic [3:0] e_rerr;
        logic [1:0] e_id;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] SA[4];
    logic [31:0] LEN[4];
    int          n_vec = 0;
    int          n_bad = 0;
    string       phase = "init";

    function automatic vec_t mk(input logic rst, input logic [3:0] rv, input logic cr, input logic irq,
                                input logic [3:0] err, input logic [3:0] e_rdy, input logic e_cfgv,
                                input logic e_busy, input logic [3:0] e_done, input logic e_w1c,
                                input logic [3:0] e_rerr, input logic [1:0] e_id);
        vec_t v;
        v.rst = rst; v.rv = rv; v.cr = cr; v.irq = irq; v.err = err;
        v.e_rdy = e_rdy; v.e_cfgv = e_cfgv; v.e_busy = e_busy; v.e_done = e_done;
        v.e_w1c = e_w1c; v.e_rerr = e_rerr; v.e_id = e_id;
        return v;
    endfunction

    // Drive one cycle's inputs at negedge, check outputs 1ns later.
    task automatic step(input vec_t v);
        logic bad;
        logic [31:0] xsa, xlen;
        @(negedge clk);
        usr_reset = v.rst; req_valid = v.rv; cfg_dma_ready = v.cr;
        dma_irq = v.irq; dma_err = v.err;
        #1;
        bad = (req_ready !== v.e_rdy) || (cfg_dma_valid !== v.e_cfgv) || (busy !== v.e_busy) ||
              (req_done !== v.e_done) || (dma_irq_w1c !== v.e_w1c) || (req_err !== v.e_rerr) ||
              (cur_id !== v.e_id);
        xsa = SA[v.e_id]; xlen = LEN[v.e_id];
        if (v.rst) begin
            xsa = '0; xlen = '0;
        end
        if (v.rst || v.e_cfgv)
            bad = bad || (cfg_dma_sa !== xsa) || (cfg_dma_len !== xlen);
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s vec#%0d (got/exp): rdy=%b/%b cfgv=%b/%b busy=%b/%b done=%b/%b w1c=%b/%b err=%h/%h id=%0d/%0d sa=%h/%h len=%h/%h",
                     phase, n_vec, req_ready, v.e_rdy, cfg_dma_valid, v.e_cfgv, busy, v.e_busy,
                     req_done, v.e_done, dma_irq_w1c, v.e_w1c, req_err, v.e_rerr, cur_id, v.e_id,
                     cfg_dma_sa, xsa, cfg_dma_len, xlen);
        end
    endtask

    initial begin
        int prev;
        for (int i = 0; i < 4; i++) begin
            SA[i]  = 32'h1000 + 32'h1000 * i;
            LEN[i] = 32'h400 + 32'h40 * i;
            req_sa[i*32 +: 32]  = SA[i];
            req_len[i*32 +: 32] = LEN[i];
        end
        usr_reset = 1'b1; req_valid = '0; cfg_dma_ready = 1'b0; dma_irq = 1'b0; dma_err = '0;

        // Single command from requester 0, zero error.
        tbl.push_back(mk(1, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h1, 0, 0, 0,  4'h1, 0, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0, 0,  4'h0, 1, 1, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 1, 0,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 1, 0,  4'h0, 0, 1, 4'h1, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 1, 0,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h0, 0, 0, 0));

        // All requesters valid: grants 0,1,2,3,0; error captured in BUSY, input zeroed in CLR.
        tbl.push_back(mk(1, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h0, 0, 0, 0));
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            int g;
            logic [3:0] e, oh;
            g = k % 4; e = 4'(k + 3); oh = 4'(1 << g);
            tbl.push_back(mk(0, 4'hF, 0, 0, 0,  oh,   0, 0, 4'h0, 0, 0, 2'(prev)));
            tbl.push_back(mk(0, 4'hF, 1, 0, 0,  4'h0, 1, 1, 4'h0, 0, 0, 2'(g)));
            tbl.push_back(mk(0, 4'hF, 0, 1, e,  4'h0, 0, 1, 4'h0, 0, 0, 2'(g)));
            tbl.push_back(mk(0, 4'hF, 0, 1, 0,  4'h0, 0, 1, oh,   1, e, 2'(g)));
            tbl.push_back(mk(0, 4'hF, 0, 0, 0,  4'h0, 0, 1, 4'h0, 0, 0, 2'(g)));
            prev = g;
        end

        // cfg_dma_ready stalled 7 cycles: valid held 8 cycles, no grants meanwhile.
        tbl.push_back(mk(1, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h1, 0, 0, 0,  4'h1, 0, 0, 4'h0, 0, 0, 0));
        for (int s = 0; s < 7; s++)
            tbl.push_back(mk(0, 4'hF, 0, 0, 0,  4'h0, 1, 1, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 1, 0, 0,  4'h0, 1, 1, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 1, 2,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 1, 0,  4'h0, 0, 1, 4'h1, 1, 2, 0));
        tbl.push_back(mk(0, 4'hF, 0, 0, 0,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 0, 0,  4'h2, 0, 0, 4'h0, 0, 0, 0));

        phase = "table";
        foreach (tbl[i]) step(tbl[i]);

        // Stale irq: no grant while irq high, grant only the cycle after it falls.
        phase = "irq_drain";
        step(mk(1, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h0, 0, 0, 0));
        step(mk(0, 4'h4, 0, 1, 0,  4'h0, 0, 0, 4'h0, 0, 0, 0));
        step(mk(0, 4'h1, 0, 0, 0,  4'h1, 0, 0, 4'h0, 0, 0, 0));
        step(mk(0, 4'h4, 1, 0, 0,  4'h0, 1, 1, 4'h0, 0, 0, 0));
        step(mk(0, 4'h4, 0, 1, 0,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        step(mk(0, 4'h4, 0, 1, 0,  4'h0, 0, 1, 4'h1, 1, 0, 0));
        for (int s = 0; s < 3; s++)
            step(mk(0, 4'h4, 0, 1, 0,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        step(mk(0, 4'h4, 0, 0, 0,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        step(mk(0, 4'h4, 0, 0, 0,  4'h4, 0, 0, 4'h0, 0, 0, 0));

        // Reset in BUSY abandons the command; a later irq is not a completion.
        phase = "reset_busy";
        step(mk(1, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h0, 0, 0, 0));
        step(mk(0, 4'h1, 0, 0, 0,  4'h1, 0, 0, 4'h0, 0, 0, 0));
        step(mk(0, 4'h0, 1, 0, 0,  4'h0, 1, 1, 4'h0, 0, 0, 0));
        step(mk(0, 4'h0, 0, 0, 0,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        step(mk(0, 4'h0, 0, 0, 0,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        step(mk(1, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h0, 0, 0, 0));
        for (int s = 0; s < 5; s++)
            step(mk(0, 4'h0, 0, 1, 3,  4'h0, 0, 0, 4'h0, 0, 0, 0));
        step(mk(0, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h0, 0, 0, 0));
        step(mk(0, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h0, 0, 0, 0));

        // Watchdog behaviour with no irq.
        phase = "watchdog";
        step(mk(1, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h0, 0, 0, 0));
        step(mk(0, 4'h1, 0, 0, 0,  4'h1, 0, 0, 4'h0, 0, 0, 0));
        step(mk(0, 4'h0, 1, 0, 0,  4'h0, 1, 1, 4'h0, 0, 0, 0));
`ifdef AMI_DMA_SCHED_WDOG_EN
        for (int j = 0; j < 20; j++)
            step(mk(0, 4'h0, 0, 0, 0,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        step(mk(0, 4'h0, 0, 0, 0,  4'h0, 0, 1, 4'h1, 1, 4'hF, 0));
        step(mk(0, 4'h0, 0, 0, 0,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        step(mk(0, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h0, 0, 0, 0));
        // irq in the timeout cycle: engine error wins.
        phase = "wdog_vs_irq";
        step(mk(0, 4'h1, 0, 0, 0,  4'h1, 0, 0, 4'h0, 0, 0, 0));
        step(mk(0, 4'h0, 1, 0, 0,  4'h0, 1, 1, 4'h0, 0, 0, 0));
        for (int j = 0; j < 19; j++)
            step(mk(0, 4'h0, 0, 0, 0,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        step(mk(0, 4'h0, 0, 1, 5,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        step(mk(0, 4'h0, 0, 0, 0,  4'h0, 0, 1, 4'h1, 1, 4'h5, 0));
        step(mk(0, 4'h0, 0, 0, 0,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        step(mk(0, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h0, 0, 0, 0));
`else
        for (int j = 0; j < 1000; j++)
            step(mk(0, 4'h0, 0, 0, 0,  4'h0, 0, 1, 4'h0, 0, 0, 0));
        step(mk(1, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h0, 0, 0, 0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ami_dma_sched.md
AMI_DMA_SCHED -- requirements
Module: ami_dma_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of DMA requesters (2..8).
REQ-002 SHALL have parameter IW, default $clog2(NREQ): requester index width.
REQ-003 SHALL have parameter TIMEOUT, default 65535: watchdog limit in cycles, 16-bit.
REQ-004 SHALL use one clock and a synchronous, active-high reset, named as follows.
  - usr_clk  in  1: single clock.
  - usr_reset  in  1: synchronous active-high reset.
REQ-005 SHALL have these requester-side ports:
  - req_valid  in  NREQ: per-requester command valid.
  - req_ready  out  NREQ: per-requester command accept.
  - req_sa  in  NREQ*32: per-requester start address; slice i is [32i+31:32i].
  - req_len  in  NREQ*32: per-requester byte length.
  - req_done  out  NREQ: one-cycle completion pulse to the owning requester.
  - req_err  out  4: completion error code, valid while any req_done is high.
REQ-006 SHALL have these DMA-engine-side ports:
  - cfg_dma_valid  out  1: command to axlen_partition.
  - cfg_dma_ready  in  1: command accepted.
  - cfg_dma_sa  out  32: command start address.
  - cfg_dma_len  out  32: command byte length.
  - dma_irq  in  1: engine done level.
  - dma_irq_w1c  out  1: interrupt clear pulse.
  - dma_err  in  4: engine error code.
REQ-007 SHALL have these status ports:
  - busy  out  1: high in any state except IDLE.
  - cur_id  out  IW: index of the current owner.

Function
REQ-008 SHALL implement the FSM states IDLE, CFG, BUSY, CLR and DRAIN.
REQ-009 SHALL, in IDLE, grant round-robin: the first asserted req_valid searching from index ptr+1 modulo NREQ upward.
REQ-010 SHALL drive req_ready combinationally: high only for the granted index, and only in IDLE with dma_irq low.
REQ-011 SHALL, on req_valid&req_ready, do all of the following: register req_sa/req_len slices and the index; set ptr to that index; go to CFG.
REQ-012 SHALL, in CFG, hold cfg_dma_valid high with cfg_dma_sa/len stable until cfg_dma_ready is sampled high, then go to BUSY (minimum one CFG cycle).
REQ-013 SHALL deassert cfg_dma_valid in every state except CFG.
REQ-014 SHALL, in BUSY, wait for dma_irq high, capture dma_err and go to CLR.
REQ-015 SHALL, in CLR (exactly one cycle), assert dma_irq_w1c, req_done[cur_id] and req_err (the captured error), then go to DRAIN.
REQ-016 SHALL, in DRAIN, wait for dma_irq low, then go to IDLE; this prevents a stale irq completing the next command.
REQ-017 SHALL make the minimum command-to-command spacing 5 cycles (IDLE, CFG, BUSY, CLR, DRAIN); no back-to-back acceptance.
REQ-018 SHALL accept requests of zero length unaltered; reporting them is left to dma_err.
REQ-019 SHALL ignore req_valid changes while not in IDLE; requesters hold req_valid and data until req_ready.
REQ-020 SHALL give precedence to dma_irq over the watchdog when both occur in the same BUSY cycle.

Reset
REQ-021 SHALL, on usr_reset, set: state IDLE; ptr NREQ-1, so requester 0 has first priority; cur_id 0; captured error 0.
REQ-022 SHALL, on usr_reset, drive all outputs low: cfg_dma_valid, dma_irq_w1c, req_done, req_err, busy, cfg_dma_sa, cfg_dma_len.
REQ-023 SHALL, on reset asserted mid-operation, abandon the command with no req_done and no dma_irq_w1c; the first cycle after reset is IDLE.

Configuration
REQ-024 SHALL gate a BUSY watchdog with macro AMI_DMA_SCHED_WDOG_EN.
  - Defined: a 16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT without dma_irq: go to CLR with req_err=4'hF; dma_irq_w1c is still pulsed.
  - Not defined: no counter; BUSY waits indefinitely.

Verification
REQ-025 Reset then req_valid=4'b0001, sa=0x1000, len=0x400 -> req_ready[0] same cycle; next cycle cfg_dma_valid=1, sa=0x1000, len=0x400; when irq arrives with dma_err=0, req_done[0]=1 and req_err=0 in the cycle dma_irq_w1c=1.
REQ-026 req_valid=4'b1111 held across four commands -> grant order 0,1,2,3, then 0 again.
REQ-027 cfg_dma_ready stalled 7 cycles -> cfg_dma_valid high 8 cycles, sa/len unchanged, no req_ready pulses meanwhile.
REQ-028 dma_irq held high 3 cycles after w1c with req_valid[2]=1 -> no req_ready until the cycle after dma_irq falls.
REQ-029 usr_reset asserted in BUSY -> next cycle state IDLE, busy=0, no req_done; a later dma_irq with no command pending is not accepted as a completion.
REQ-030 With AMI_DMA_SCHED_WDOG_EN defined, TIMEOUT=20 and no irq -> req_done pulses 20 cycles after BUSY entry with req_err=4'hF; without the macro, no req_done after 1000 cycles.
